// File: rtl/ram_dp_arb2.sv
// ram_dp_arb2: two-client arbiter around a 2**AW x DW memory with one write
// port and one registered read port. Each port has its own round-robin
// pointer, so a write from one client and a read from the other are both
// accepted in the same cycle.
module ram_dp_arb2 #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          c0_req,
   input  logic          c0_we,
   input  logic [AW-1:0] c0_addr,
   input  logic [DW-1:0] c0_wdata,
   output logic          c0_gnt,
   output logic          c0_rvalid,
   output logic [DW-1:0] c0_rdata,
   input  logic          c1_req,
   input  logic          c1_we,
   input  logic [AW-1:0] c1_addr,
   input  logic [DW-1:0] c1_wdata,
   output logic          c1_gnt,
   output logic          c1_rvalid,
   output logic [DW-1:0] c1_rdata
);

   localparam int DEPTH = 2 ** AW;

   logic [DW-1:0] r_mem [DEPTH];
   logic          r_wr_prio;   // favoured client on the write port
   logic          r_rd_prio;   // favoured client on the read port
   logic          r_c0_rvalid;
   logic          r_c1_rvalid;
   logic [DW-1:0] r_c0_rdata;
   logic [DW-1:0] r_c1_rdata;

   logic w_c0_wr, w_c1_wr, w_c0_rd, w_c1_rd;
   logic w_c0_wgnt, w_c1_wgnt, w_c0_rgnt, w_c1_rgnt;

   // Split each client's command onto the port it needs.
   assign w_c0_wr = c0_req &  c0_we;
   assign w_c1_wr = c1_req &  c1_we;
   assign w_c0_rd = c0_req & ~c0_we;
   assign w_c1_rd = c1_req & ~c1_we;

   // A lone requester always wins; on contention the pointer decides.
   // Nothing is granted while reset is high.
   assign w_c0_wgnt = ~reset & w_c0_wr & (~w_c1_wr | ~r_wr_prio);
   assign w_c1_wgnt = ~reset & w_c1_wr & (~w_c0_wr |  r_wr_prio);
   assign w_c0_rgnt = ~reset & w_c0_rd & (~w_c1_rd | ~r_rd_prio);
   assign w_c1_rgnt = ~reset & w_c1_rd & (~w_c0_rd |  r_rd_prio);

   assign c0_gnt    = w_c0_wgnt | w_c0_rgnt;
   assign c1_gnt    = w_c1_wgnt | w_c1_rgnt;
   assign c0_rvalid = r_c0_rvalid;
   assign c1_rvalid = r_c1_rvalid;
   assign c0_rdata  = r_c0_rdata;
   assign c1_rdata  = r_c1_rdata;

   // Storage: cleared on reset, written by whichever client holds the write grant.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_c0_wgnt) begin
         r_mem[c0_addr] <= c0_wdata;
      end else if (w_c1_wgnt) begin
         r_mem[c1_addr] <= c1_wdata;
      end
   end

   // Priority pointers: after a grant, favour the client that was not granted.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_prio <= 1'b0;
         r_rd_prio <= 1'b0;
      end else begin
         if (w_c0_wgnt | w_c1_wgnt) r_wr_prio <= w_c0_wgnt;
         if (w_c0_rgnt | w_c1_rgnt) r_rd_prio <= w_c0_rgnt;
      end
   end

   // Registered read port; sampling r_mem before the write lands gives
   // old data on a same-cycle read-during-write. rdata holds when idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_c0_rvalid <= 1'b0;
         r_c1_rvalid <= 1'b0;
         r_c0_rdata  <= '0;
         r_c1_rdata  <= '0;
      end else begin
         r_c0_rvalid <= w_c0_rgnt;
         r_c1_rvalid <= w_c1_rgnt;
         if (w_c0_rgnt) r_c0_rdata <= r_mem[c0_addr];
         if (w_c1_rgnt) r_c1_rdata <= r_mem[c1_addr];
      end
   end

endmodule

// File: tb/tb_ram_dp_arb2.sv
// Self-checking bench for ram_dp_arb2. Read results are predicted when a
// read is issued (pushed to a per-client queue) and compared by a monitor
// when rvalid appears.
module tb_ram_dp_arb2;

   localparam int DW = 8;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          c0_req = 1'b0, c0_we = 1'b0;
   logic [AW-1:0] c0_addr = '0;
   logic [DW-1:0] c0_wdata = '0;
   logic          c1_req = 1'b0, c1_we = 1'b0;
   logic [AW-1:0] c1_addr = '0;
   logic [DW-1:0] c1_wdata = '0;
   logic          c0_gnt, c0_rvalid, c1_gnt, c1_rvalid;
   logic [DW-1:0] c0_rdata, c1_rdata;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];

   ram_dp_arb2 #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .reset(reset),
      .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
      .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
      .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
      .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata)
   );

   always #5 clk = ~clk;

   // Hard stop if the run ever gets stuck.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "watchdog");
   end

   // Scoreboard monitor: every rvalid must match the oldest predicted read.
   always @(negedge clk) begin
      if (c0_rvalid === 1'b1) begin
         checks++;
         if (q0.size() == 0) begin
            errors++;
            $display("FAIL c0_rvalid_unexpected: got rvalid=1 rdata=%02h, required no read pending", c0_rdata);
         end else begin
            logic [DW-1:0] e0;
            e0 = q0.pop_front();
            if (c0_rdata !== e0) begin
               errors++;
               $display("FAIL c0_rdata: got %02h required %02h", c0_rdata, e0);
            end
         end
      end
      if (c1_rvalid === 1'b1) begin
         checks++;
         if (q1.size() == 0) begin
            errors++;
            $display("FAIL c1_rvalid_unexpected: got rvalid=1 rdata=%02h, required no read pending", c1_rdata);
         end else begin
            logic [DW-1:0] e1;
            e1 = q1.pop_front();
            if (c1_rdata !== e1) begin
               errors++;
               $display("FAIL c1_rdata: got %02h required %02h", c1_rdata, e1);
            end
         end
      end
   end

   task automatic set_c0(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      c0_req = req; c0_we = we; c0_addr = a; c0_wdata = d;
   endtask

   task automatic set_c1(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      c1_req = req; c1_we = we; c1_addr = a; c1_wdata = d;
   endtask

   task automatic next_edge();
      @(posedge clk); #1;
   endtask

   // One reset cycle with c0 requesting; gnt must stay low and outputs clear.
   task automatic test_reset();
      reset = 1'b1;
      set_c0(1'b1, 1'b0, 4'd0, 8'h00);
      set_c1(1'b1, 1'b1, 4'd1, 8'hEE);
      @(negedge clk);
      checks++;
      if (c0_gnt !== 1'b0 || c1_gnt !== 1'b0) begin
         errors++;
         $display("FAIL reset_gnt: got c0_gnt=%b c1_gnt=%b required 0 0", c0_gnt, c1_gnt);
      end
      next_edge();
      q0.delete(); q1.delete();
      reset = 1'b0;
      set_c0(1'b0, 1'b0, 4'd0, 8'h00);
      set_c1(1'b0, 1'b0, 4'd0, 8'h00);
      @(negedge clk);
      checks++;
      if (c0_rvalid !== 1'b0 || c1_rvalid !== 1'b0 || c0_rdata !== 8'h00 || c1_rdata !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs: got rv=%b/%b rd=%02h/%02h required 0/0 00/00",
                  c0_rvalid, c1_rvalid, c0_rdata, c1_rdata);
      end
      next_edge();
   endtask

   // After reset every location reads as zero.
   task automatic test_clear();
      for (int i = 0; i < 16; i++) begin
         set_c0(1'b1, 1'b0, AW'(i), 8'h00);
         q0.push_back(8'h00);
         @(negedge clk);
         checks++;
         if (c0_gnt !== 1'b1) begin
            errors++;
            $display("FAIL clear_gnt[%0d]: got %b required 1", i, c0_gnt);
         end
         next_edge();
      end
      set_c0(1'b0, 1'b0, 4'd0, 8'h00);
      next_edge();
   endtask

   // c0 fills memory, c1 reads it back with rvalid high every cycle.
   task automatic test_back_to_back();
      for (int i = 0; i < 16; i++) begin
         set_c0(1'b1, 1'b1, AW'(i), DW'(i + 20));
         @(negedge clk);
         checks++;
         if (c0_gnt !== 1'b1) begin
            errors++;
            $display("FAIL fill_gnt[%0d]: got %b required 1", i, c0_gnt);
         end
         next_edge();
      end
      set_c0(1'b0, 1'b0, 4'd0, 8'h00);
      for (int i = 0; i < 16; i++) begin
         set_c1(1'b1, 1'b0, AW'(i), 8'h00);
         q1.push_back(DW'(i + 20));
         @(negedge clk);
         checks++;
         if (c1_gnt !== 1'b1 || (i > 0 && c1_rvalid !== 1'b1)) begin
            errors++;
            $display("FAIL b2b_read[%0d]: got gnt=%b rvalid=%b required 1 1", i, c1_gnt, c1_rvalid);
         end
         next_edge();
      end
      set_c1(1'b0, 1'b0, 4'd0, 8'h00);
      @(negedge clk);
      checks++;
      if (c1_rvalid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_last_rvalid: got %b required 1", c1_rvalid);
      end
      next_edge();
      @(negedge clk);
      checks++;
      if (c1_rvalid !== 1'b0 || c1_rdata !== 8'd35) begin
         errors++;
         $display("FAIL b2b_idle: got rvalid=%b rdata=%02h required 0 23", c1_rvalid, c1_rdata);
      end
      next_edge();
   endtask

   // Both write addr 3: c0 first, then c1; pointer returns to c0.
   task automatic test_write_contention();
      set_c0(1'b1, 1'b1, 4'd3, 8'hAA);
      set_c1(1'b1, 1'b1, 4'd3, 8'h55);
      @(negedge clk);
      checks++;
      if (c0_gnt !== 1'b1 || c1_gnt !== 1'b0) begin
         errors++;
         $display("FAIL wr_cont_first: got c0=%b c1=%b required 1 0", c0_gnt, c1_gnt);
      end
      next_edge();
      set_c0(1'b0, 1'b0, 4'd0, 8'h00);
      @(negedge clk);
      checks++;
      if (c0_gnt !== 1'b0 || c1_gnt !== 1'b1) begin
         errors++;
         $display("FAIL wr_cont_second: got c0=%b c1=%b required 0 1", c0_gnt, c1_gnt);
      end
      next_edge();
      // Pointer must now favour c0 again.
      set_c0(1'b1, 1'b1, 4'd4, 8'h0C);
      set_c1(1'b1, 1'b1, 4'd4, 8'h1C);
      @(negedge clk);
      checks++;
      if (c0_gnt !== 1'b1 || c1_gnt !== 1'b0) begin
         errors++;
         $display("FAIL wr_prio_end: got c0=%b c1=%b required 1 0", c0_gnt, c1_gnt);
      end
      next_edge();
      set_c0(1'b0, 1'b0, 4'd0, 8'h00);
      next_edge();
      set_c1(1'b0, 1'b0, 4'd0, 8'h00);
      set_c0(1'b1, 1'b0, 4'd3, 8'h00);
      q0.push_back(8'h55);
      next_edge();
      set_c0(1'b1, 1'b0, 4'd4, 8'h00);
      q0.push_back(8'h1C);
      next_edge();
      set_c0(1'b0, 1'b0, 4'd0, 8'h00);
      next_edge();
   endtask

   // Both read addr 5 for 6 cycles: grants alternate starting with c0.
   task automatic test_read_round_robin();
      set_c0(1'b1, 1'b1, 4'd5, 8'h11);
      next_edge();
      set_c0(1'b1, 1'b0, 4'd5, 8'h00);
      set_c1(1'b1, 1'b0, 4'd5, 8'h00);
      for (int k = 0; k < 6; k++) begin
         logic e0;
         e0 = (k % 2 == 0);
         if (e0) q0.push_back(8'h11); else q1.push_back(8'h11);
         @(negedge clk);
         checks++;
         if (c0_gnt !== e0 || c1_gnt !== ~e0) begin
            errors++;
            $display("FAIL rd_rr[%0d]: got c0=%b c1=%b required %b %b", k, c0_gnt, c1_gnt, e0, ~e0);
         end
         if (k > 0) begin
            checks++;
            if (c0_rvalid !== ~e0 || c1_rvalid !== e0) begin
               errors++;
               $display("FAIL rd_rr_rvalid[%0d]: got %b %b required %b %b", k, c0_rvalid, c1_rvalid, ~e0, e0);
            end
         end
         next_edge();
      end
      set_c0(1'b0, 1'b0, 4'd0, 8'h00);
      set_c1(1'b0, 1'b0, 4'd0, 8'h00);
      next_edge();
   endtask

   // c0 writes addr 7 while c1 reads it: old data, then new data.
   task automatic test_read_during_write();
      set_c0(1'b1, 1'b1, 4'd7, 8'h01);
      next_edge();
      set_c0(1'b1, 1'b1, 4'd7, 8'h02);
      set_c1(1'b1, 1'b0, 4'd7, 8'h00);
      q1.push_back(8'h01);
      @(negedge clk);
      checks++;
      if (c0_gnt !== 1'b1 || c1_gnt !== 1'b1) begin
         errors++;
         $display("FAIL rdw_both_gnt: got c0=%b c1=%b required 1 1", c0_gnt, c1_gnt);
      end
      next_edge();
      set_c0(1'b0, 1'b0, 4'd0, 8'h00);
      q1.push_back(8'h02);
      next_edge();
      set_c1(1'b0, 1'b0, 4'd0, 8'h00);
      next_edge();
   endtask

   // Reset lands one edge after a c1 read grant while c0 wants to write.
   task automatic test_reset_mid_op();
      set_c1(1'b1, 1'b1, 4'd2, 8'h33);
      next_edge();
      set_c1(1'b1, 1'b0, 4'd2, 8'h00);
      q1.push_back(8'h33);
      next_edge();                      // edge N
      reset = 1'b1;
      set_c1(1'b0, 1'b0, 4'd0, 8'h00);
      set_c0(1'b1, 1'b1, 4'd2, 8'h44);
      @(negedge clk);
      checks++;
      if (c1_rvalid !== 1'b1 || c0_gnt !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_before: got c1_rvalid=%b c0_gnt=%b required 1 0", c1_rvalid, c0_gnt);
      end
      next_edge();                      // edge N+1
      reset = 1'b0;
      set_c0(1'b0, 1'b0, 4'd0, 8'h00);
      @(negedge clk);
      checks++;
      if (c0_rvalid !== 1'b0 || c1_rvalid !== 1'b0 || c0_rdata !== 8'h00 || c1_rdata !== 8'h00) begin
         errors++;
         $display("FAIL rst_mid_outputs: got rv=%b/%b rd=%02h/%02h required 0/0 00/00",
                  c0_rvalid, c1_rvalid, c0_rdata, c1_rdata);
      end
      set_c0(1'b1, 1'b0, 4'd2, 8'h00);
      q0.push_back(8'h00);
      next_edge();
      set_c0(1'b0, 1'b0, 4'd0, 8'h00);
      next_edge();
   endtask

   initial begin
      test_reset();
      test_clear();
      test_back_to_back();
      test_reset();
      test_write_contention();
      test_reset();
      test_read_round_robin();
      test_reset();
      test_read_during_write();
      test_reset();
      test_reset_mid_op();
      checks++;
      if (q0.size() != 0 || q1.size() != 0) begin
         errors++;
         $display("FAIL missing_reads: got pending %0d/%0d required 0/0", q0.size(), q1.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_dp_arb2.md
# ram_dp_arb2

Two-client arbiter wrapped around a 16x8 dual-port RAM (one write port, one registered read port). Two independent requesters share the memory. Per port, contention is resolved round-robin, so a write from one client and a read from the other complete in the same cycle. The block sits between two datapath masters and the shared buffer and owns the storage array internally.

## Interface

**Parameters**
- DW, 8, data width
- AW, 4, address width; depth = 2**AW (16)

**Ports**
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- c0_req  in  1  client 0 command valid
- c0_we  in  1  client 0 command type: 1 = write, 0 = read
- c0_addr  in  AW  client 0 address
- c0_wdata  in  DW  client 0 write data
- c0_gnt  out  1  client 0 command accepted this cycle (combinational)
- c0_rvalid  out  1  client 0 read data valid (registered)
- c0_rdata  out  DW  client 0 read data (registered)
- c1_req, c1_we, c1_addr, c1_wdata, c1_gnt, c1_rvalid, c1_rdata: same as client 0, for client 1

## Operation

**Handshake**
- A client asserts req with we/addr/wdata stable and holds them until gnt=1.
- Transfer occurs at the rising edge where req & gnt = 1.
- The client may issue a new command in the following cycle or drop req.

**Port split**
- Write commands compete only for the write port. Read commands compete only for the read port.
- c0 write + c1 read (or the reverse) in the same cycle: both granted.

**Arbitration**
- Each port has its own 1-bit priority pointer, wr_prio and rd_prio; the value names the favoured client.
- Single requester on a port: granted immediately, regardless of the pointer.
- Both clients request the same port: the client named by the pointer is granted; the other waits.
- After any grant on a port, that port's pointer is set to the non-granted client. This guarantees a blocked client wins the next contention.
- A port with no grant leaves its pointer unchanged.

**Write**
- mem[addr] <= wdata at the transfer edge.

**Read**
- rdata of the granted client <= mem[addr] at the transfer edge, and its rvalid = 1 for exactly one cycle.
- Read-during-write to the same address in the same cycle returns the OLD contents.
- rdata holds its last value while rvalid = 0.
- The other client's rdata and rvalid are unaffected.

**Reset**
- All mem locations cleared to 0.
- c0_rdata, c1_rdata = 0; c0_rvalid, c1_rvalid = 0.
- wr_prio = rd_prio = client 0.
- c0_gnt, c1_gnt forced to 0 while reset = 1.

## Timing

- Grant latency:
  - 0 cycles when uncontended (gnt in the same cycle as req).
  - At most 1 extra cycle under contention, since an alternating pointer bounds wait to one transfer.
- Read latency: 1 cycle. Transfer at edge N gives rvalid/rdata visible after edge N, for one cycle only.
- Write is visible to a read granted at edge N+1 or later.
- Back-to-back reads by one client: rvalid stays high on consecutive cycles, with new rdata each cycle.
- Reset asserted mid-operation:
  - Pending requests are dropped, with no grant and no write.
  - Any rvalid due that cycle is suppressed.
  - State returns to reset values at that edge.
- The first grant possible is in the cycle after reset deasserts.
- Address wrap: none. addr is a full AW-bit index, so all 16 locations are valid.

## Test plan

1. **Reset / clear.** Apply reset for 1 cycle, then c0 reads addr 0..15. Required: every rdata = 0x00; rvalid high for 1 cycle each; c0_gnt never high during reset.
2. **Fill and readback.** c0 writes addr i with i+20 for i = 0..15; then c1 reads 0..15 back-to-back. Required: rdata sequence 20..35; rvalid high for 16 consecutive cycles, with 1-cycle latency.
3. **Write contention.** Both clients hold write requests, c0: addr 3 / 0xAA and c1: addr 3 / 0x55, from reset. Required: c0 granted first, c1 granted next cycle, final mem[3] = 0x55; wr_prio ends at client 0.
4. **Read contention round-robin.** Both clients hold continuous reads of addr 5 (= 0x11) for 6 cycles. Required: grants alternate c0, c1, c0, c1, c0, c1; each client gets rvalid every other cycle with rdata = 0x11.
5. **Concurrent ports and read-during-write.** mem[7] = 0x01; in the same cycle c0 writes addr 7 = 0x02 and c1 reads addr 7. Required: both granted that cycle; c1_rdata = 0x01; a c1 read of addr 7 next cycle returns 0x02.
6. **Reset mid-operation.** c1 read of addr 2 = 0x33 is granted at edge N; reset is asserted for edge N+1 while c0 is requesting a write of addr 2 = 0x44. Required: c1_rvalid = 1 after edge N with rdata 0x33; after edge N+1 all outputs = 0, mem[2] = 0x00, and no c0 grant.
